// File: rtl/wall_refill_sequencer.sv
// Rebuilds a player's brick wall in brick RAM after a wall-empty flag or game start.
// Writes one cell per clock during vertical blank and reports per-player wall-ready status.
module wall_refill_sequencer #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 32
) (
  input  logic                                     CLK_DRV,
  input  logic                                     RESET,
  input  logic                                     FPD1,
  input  logic                                     FPD2,
  input  logic                                     START_GAME,
  input  logic                                     VBLANK,
  output logic [$clog2(ROWS)+$clog2(COLS):0]       BRICK_ADDR,
  output logic                                     BRICK_WE,
  output logic                                     BRICK_WD,
  output logic                                     BUSY,
  output logic                                     WALL1_RDY,
  output logic                                     WALL2_RDY
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          fpd1_q;
  logic          fpd2_q;
  logic          pend1;
  logic          pend2;
  logic          player;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic req1;
  logic req2;
  logic take1;
  logic take2;
  logic col_last;
  logic last_cell;

  // Rising-edge requests; START_GAME asks for both walls.
  assign req1 = (FPD1 & ~fpd1_q) | START_GAME;
  assign req2 = (FPD2 & ~fpd2_q) | START_GAME;

  // Player 1 wins when both are pending.
  assign take1 = (state == S_IDLE) & pend1;
  assign take2 = (state == S_IDLE) & ~pend1 & pend2;

  assign col_last  = (col == CW'(COLS - 1));
  assign last_cell = (row == RW'(ROWS - 1)) & col_last;

  assign BRICK_ADDR = {player, row, col};
  assign BRICK_WE   = (state == S_SWEEP) & VBLANK;
  assign BRICK_WD   = 1'b1;

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      state     <= S_IDLE;
      fpd1_q    <= 1'b1;
      fpd2_q    <= 1'b1;
      pend1     <= 1'b0;
      pend2     <= 1'b0;
      player    <= 1'b0;
      row       <= '0;
      col       <= '0;
      BUSY      <= 1'b0;
      WALL1_RDY <= 1'b0;
      WALL2_RDY <= 1'b0;
    end else begin
      fpd1_q <= FPD1;
      fpd2_q <= FPD2;
      // A new request outranks the clear on sweep entry.
      pend1  <= req1 | (pend1 & ~take1);
      pend2  <= req2 | (pend2 & ~take2);

      case (state)
        S_IDLE: begin
          if (pend1 | pend2) begin
            state  <= S_SWEEP;
            BUSY   <= 1'b1;
            player <= ~pend1;
            row    <= '0;
            col    <= '0;
          end
        end
        S_SWEEP: begin
          // Address holds while VBLANK is low, so no cell is skipped.
          if (VBLANK) begin
            col <= col + CW'(1);
            if (col_last) begin
              row <= row + RW'(1);
            end
            if (last_cell) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          if (player) begin
            WALL2_RDY <= 1'b1;
          end else begin
            WALL1_RDY <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase

      // A request in the DONE cycle beats the ready set above.
      if (req1) begin
        WALL1_RDY <= 1'b0;
      end
      if (req2) begin
        WALL2_RDY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wall_refill_sequencer.sv
// Scoreboard bench for wall_refill_sequencer: expected write addresses are queued by the
// stimulus and popped by a monitor on every write; status outputs are checked at fixed edges.
module tb_wall_refill_sequencer;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset      = 1'b1;
  logic       fpd1       = 1'b0;
  logic       fpd2       = 1'b0;
  logic       start_game = 1'b0;
  logic       vblank     = 1'b0;
  logic [8:0] brick_addr;
  logic       brick_we;
  logic       brick_wd;
  logic       busy;
  logic       wall1_rdy;
  logic       wall2_rdy;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;
  logic [8:0] exp_q[$];

  wall_refill_sequencer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .CLK_DRV   (clk),
    .RESET     (reset),
    .FPD1      (fpd1),
    .FPD2      (fpd2),
    .START_GAME(start_game),
    .VBLANK    (vblank),
    .BRICK_ADDR(brick_addr),
    .BRICK_WE  (brick_we),
    .BRICK_WD  (brick_wd),
    .BUSY      (busy),
    .WALL1_RDY (wall1_rdy),
    .WALL2_RDY (wall2_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(9'(a));
  endtask

  // Monitor: every write must match the head of the expected-address queue.
  always @(negedge clk) begin
    if (brick_we === 1'b1) begin
      logic [8:0] exp_addr;
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we actual_addr=0x%0h expected=no write at %0t", brick_addr, $time);
      end else begin
        exp_addr = exp_q.pop_front();
        check("we_addr", 32'(brick_addr), 32'(exp_addr));
      end
      check("we_wd", 32'(brick_wd), 32'd1);
      check("we_vblank", 32'(vblank), 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic done;

    // Reset and idle
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy1", 32'(wall1_rdy), 32'd0);
    check("rst_rdy2", 32'(wall2_rdy), 32'd0);
    check("rst_we", 32'(brick_we), 32'd0);
    check("rst_addr", 32'(brick_addr), 32'd0);
    check("rst_wd", 32'(brick_wd), 32'd1);
    reset = 1'b0;
    tick(1000);
    check("idle_we_count", 32'(we_count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // FPD1 rising, held high, VBLANK always high
    vblank = 1'b1;
    push_range(0, 255);
    base = we_count;
    fpd1 = 1'b1;
    tick(1);
    check("p1_busy_e1", 32'(busy), 32'd0);
    tick(1);
    check("p1_busy_e2", 32'(busy), 32'd1);
    check("p1_addr_e2", 32'(brick_addr), 32'd0);
    tick(256);
    check("p1_rdy_e258", 32'(wall1_rdy), 32'd0);
    check("p1_busy_e258", 32'(busy), 32'd1);
    tick(1);
    check("p1_rdy_e259", 32'(wall1_rdy), 32'd1);
    check("p1_busy_e259", 32'(busy), 32'd0);
    tick(5000 - 259);
    check("p1_we_total", 32'(we_count - base), 32'd256);
    check("p1_queue_empty", 32'(exp_q.size()), 32'd0);
    fpd1 = 1'b0;
    tick(2);

    // START_GAME rebuilds both walls back to back
    push_range(0, 511);
    base = we_count;
    start_game = 1'b1;
    tick(1);
    start_game = 1'b0;
    check("sg_rdy1_cleared", 32'(wall1_rdy), 32'd0);
    tick(257);
    check("sg_busy_done1", 32'(busy), 32'd1);
    tick(1);
    check("sg_busy_idle", 32'(busy), 32'd0);
    check("sg_rdy1", 32'(wall1_rdy), 32'd1);
    check("sg_rdy2_mid", 32'(wall2_rdy), 32'd0);
    tick(1);
    check("sg_busy_p2", 32'(busy), 32'd1);
    check("sg_addr_p2", 32'(brick_addr), 32'h100);
    tick(256);
    check("sg_rdy2_done", 32'(wall2_rdy), 32'd0);
    tick(1);
    check("sg_rdy2", 32'(wall2_rdy), 32'd1);
    check("sg_rdy1_end", 32'(wall1_rdy), 32'd1);
    check("sg_busy_end", 32'(busy), 32'd0);
    check("sg_we_total", 32'(we_count - base), 32'd512);
    check("sg_queue_empty", 32'(exp_q.size()), 32'd0);
    tick(2);

    // P2 sweep with VBLANK 1 high / 3 low
    push_range(256, 511);
    base = we_count;
    vblank = 1'b0;
    fpd2 = 1'b1;
    tick(1);
    check("vb_rdy2_cleared", 32'(wall2_rdy), 32'd0);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      vblank = ((i % 4) == 0);
      tick(1);
      if (wall2_rdy) begin
        done = 1'b1;
        break;
      end
    end
    check("vb_finished", 32'(done), 32'd1);
    check("vb_we_total", 32'(we_count - base), 32'd256);
    check("vb_queue_empty", 32'(exp_q.size()), 32'd0);
    vblank = 1'b1;
    fpd2 = 1'b0;
    tick(2);

    // FPD2 rises while P1 sweep is at cell 100
    push_range(0, 511);
    base = we_count;
    fpd1 = 1'b1;
    tick(102);
    fpd2 = 1'b1;
    tick(1);
    check("q_rdy2_cleared", 32'(wall2_rdy), 32'd0);
    tick(155);
    check("q_rdy1_done", 32'(wall1_rdy), 32'd0);
    check("q_busy_done", 32'(busy), 32'd1);
    tick(1);
    check("q_rdy1", 32'(wall1_rdy), 32'd1);
    check("q_busy_idle", 32'(busy), 32'd0);
    tick(1);
    check("q_busy_p2", 32'(busy), 32'd1);
    check("q_addr_p2", 32'(brick_addr), 32'h100);
    tick(256);
    check("q_rdy2_done", 32'(wall2_rdy), 32'd0);
    tick(1);
    check("q_rdy2", 32'(wall2_rdy), 32'd1);
    check("q_we_total", 32'(we_count - base), 32'd512);
    check("q_queue_empty", 32'(exp_q.size()), 32'd0);
    fpd1 = 1'b0;
    fpd2 = 1'b0;
    tick(2);

    // RESET during a sweep at cell 50
    push_range(0, 50);
    base = we_count;
    fpd1 = 1'b1;
    tick(52);
    reset = 1'b1;
    tick(1);
    check("rs_we", 32'(brick_we), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_rdy1", 32'(wall1_rdy), 32'd0);
    check("rs_rdy2", 32'(wall2_rdy), 32'd0);
    check("rs_addr", 32'(brick_addr), 32'd0);
    check("rs_we_total", 32'(we_count - base), 32'd51);
    reset = 1'b0;
    tick(600);
    check("rs_no_resume", 32'(we_count - base), 32'd51);
    check("rs_busy_after", 32'(busy), 32'd0);
    check("rs_queue_empty", 32'(exp_q.size()), 32'd0);
    fpd1 = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wall_refill_sequencer.md
# wall_refill_sequencer

Sequencer on the receiving end of the empty-wall flags. It takes the wall-empty pulses (FPD1/FPD2) and the game-start request and rewrites every brick cell of the affected player's wall in brick RAM to "present". Writes happen only during vertical blank, one cell per clock. It reports per-player wall-ready status back to game control. It sits between the empty wall detector and the brick playfield RAM write port.

## Interface
Parameters:
- ROWS, default 8: brick rows per wall.
- COLS, default 32: brick columns per wall. ROWS and COLS are powers of two; RW = clog2(ROWS), CW = clog2(COLS).

Ports:
- CLK_DRV  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- FPD1  in  1  player-1 wall-empty flag, active-high, multi-ms level.
- FPD2  in  1  player-2 wall-empty flag, active-high.
- START_GAME  in  1  single-cycle pulse that requests a rebuild of both walls.
- VBLANK  in  1  high when brick RAM writes are permitted.
- BRICK_ADDR  out  1+RW+CW  write address {player(0=P1), row, col}.
- BRICK_WE  out  1  brick RAM write enable.
- BRICK_WD  out  1  write data; constant 1 (brick present).
- BUSY  out  1  high in SWEEP or DONE.
- WALL1_RDY  out  1  player-1 wall fully rebuilt since its last request.
- WALL2_RDY  out  1  player-2 wall fully rebuilt since its last request.

## Operation
- Edge detect: a request is generated on a FPDn rising edge (registered previous value 0, current 1). A level that stays high makes only one request. START_GAME requests both players.
- Each player has a pending flag, set by its request. Any request clears that player's WALLn_RDY on the same edge that sets pending.
- The FSM has three states:
  - IDLE: if pend1, go to SWEEP with player 0. Else if pend2, go to SWEEP with player 1. Else stay. Player 1 has priority when both are pending. On entry to SWEEP, clear the selected player's pending flag and set row=0, col=0.
  - SWEEP: BRICK_WE = VBLANK (combinational from state). When WE=1, advance col. On col wrap (COLS-1 to 0), advance row. After the write of cell (ROWS-1, COLS-1), go to DONE. When VBLANK=0, hold the address with WE=0 (pause, no skipped cells).
  - DONE: set WALLn_RDY for the swept player and return to IDLE. DONE lasts one cycle and has no WE.
- A request for the player currently being swept sets pending again. The sweep in progress completes normally: WALLn_RDY is set, then cleared again by the re-pend only if that request arrives in the DONE cycle or later. Pending then causes a second full sweep.
- A request for the other player during a sweep is queued (pending) and served after DONE.
- A request arriving in the same cycle as the pending-clear of that player's SWEEP entry wins: pending ends at 1.
- RESET during a sweep aborts it immediately. No further WE is issued. Cells already written stay written.

## Timing
- Reset values: state IDLE, BRICK_ADDR 0, BRICK_WE 0, BRICK_WD 1, BUSY 0, WALL1_RDY 0, WALL2_RDY 0, pend1/pend2 0. The FPD previous-value registers reset to 1, so a level already high at reset release produces no request.
- Latency with VBLANK held high, counting FPD1 rising sampled at edge t:
  - pend1 is set at t.
  - SWEEP is entered at t+1.
  - The first WE cycle (addr 0) is between t+1 and t+2.
  - Writes run for ROWS*COLS consecutive cycles, at addresses 0 … ROWS*COLS-1.
  - DONE follows.
  - WALL1_RDY rises one cycle after DONE is entered.
  - Total from the request to the WALL1_RDY rise is ROWS*COLS + 3 edges.
- BRICK_ADDR changes only on a WE cycle or on SWEEP entry. The address MSB is stable for the whole sweep.
- Throughput: one cell per clock while VBLANK=1. No gap cycles between consecutive writes.

## Test plan
- Reset then idle: all outputs at reset values, no WE for 1000 cycles with FPD1=FPD2=0.
- FPD1 0→1 held 5000 cycles, VBLANK=1, ROWS=8, COLS=32:
  - exactly 256 WE pulses at addresses 0x000…0x0FF;
  - WALL1_RDY=1 at request+259;
  - no second sweep while FPD1 stays high.
- START_GAME pulse:
  - P1 sweep at 0x000–0x0FF, then DONE;
  - P2 sweep at 0x100–0x1FF;
  - both RDY=1 at the end;
  - BUSY drops for exactly one IDLE cycle between the sweeps.
- VBLANK toggling 1 cycle high / 3 low during a P2 sweep:
  - 256 WE total, no address skipped or repeated;
  - WE only when VBLANK=1.
- FPD2 rising during P1 sweep at cell 100: P2 sweep starts right after P1 DONE, and WALL2_RDY is 0 until P2 DONE.
- RESET asserted at cell 50 of a sweep: WE=0 on the next cycle; BUSY=0, RDY=0, pending=0; no sweep resumes after reset is released.
